watch2count: RTL and testbench

//   Inverse of the pulse-count-to-watch converter. Takes a time value given as

---
 rtl/watch2count.sv | 77 +++++++
 tb/tb_watch2count.sv | 126 ++++++++++++
 2 files changed

// File: rtl/watch2count.sv
// watch2count: converts hr/min/s/ms fields into a total ms pulse count over a 5-cycle shift-add FSM
module watch2count #(
  parameter int BITS = 26
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [10:0]     ms,
  input  logic [6:0]      s,
  input  logic [6:0]      min,
  input  logic [3:0]      hr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] count,
  output logic            err,
  output logic            ovf
);
  typedef enum logic [2:0] {IDLE, MUL_MIN, MUL_S, MUL_MS, OUT} state_t;
  state_t            r_state, w_state_nxt;
  logic [26:0]       r_acc, w_mul60, w_mul1000;
  logic [10:0]       r_ms;
  logic [6:0]        r_s, r_min;
  logic              r_err, r_ovf;
  logic [BITS-1:0]   r_count;
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == OUT;
  assign count     = r_count;
  assign err       = r_err;
  assign ovf       = r_ovf;
  // acc*60 = (acc<<6)-(acc<<2); acc*1000 = (acc<<10)-(acc<<4)-(acc<<3)
  assign w_mul60   = (r_acc << 6) - (r_acc << 2) + 27'(r_state == MUL_MIN ? r_min : r_s);
  assign w_mul1000 = (r_acc << 10) - (r_acc << 4) - (r_acc << 3) + 27'(r_ms);
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = in_valid ? MUL_MIN : IDLE;
      MUL_MIN: w_state_nxt = MUL_S;
      MUL_S:   w_state_nxt = MUL_MS;
      MUL_MS:  w_state_nxt = OUT;
      OUT:     w_state_nxt = out_ready ? IDLE : OUT;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_acc   <= '0;
      r_ms    <= '0;
      r_s     <= '0;
      r_min   <= '0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_acc <= 27'(hr);
          r_ms  <= ms;
          r_s   <= s;
          r_min <= min;
          r_err <= (ms > 11'd999) || (s > 7'd59) || (min > 7'd59) || (hr > 4'd9);
        end
        MUL_MIN, MUL_S: r_acc <= w_mul60;
        MUL_MS: begin
          r_acc   <= w_mul1000;
          r_count <= r_err ? '0 : w_mul1000[BITS-1:0];
          r_ovf   <= !r_err && ((w_mul1000 >> BITS) != 27'd0);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_watch2count.sv
// tb_watch2count: table-driven checks of watch2count at BITS=26 and BITS=20, plus backpressure and reset sequences
module tb_watch2count;
  logic        clk = 1'b0, nreset = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [10:0] t_ms = '0;
  logic [6:0]  t_s = '0, t_min = '0;
  logic [3:0]  t_hr = '0;
  logic        in_ready, out_valid, err, ovf, in_ready20, out_valid20, err20, ovf20;
  logic [25:0] count;
  logic [19:0] count20;
  int          n_chk = 0, n_err = 0;
  typedef struct {
    logic [3:0]  hr;
    logic [6:0]  mi;
    logic [6:0]  s;
    logic [10:0] ms;
    logic [25:0] c;
    logic        e;
    logic        o;
    logic [19:0] c20;
    logic        o20;
  } vec_t;
  vec_t tbl[11];
  always #5 clk = ~clk;
  watch2count #(.BITS(26)) u0 (
    .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ready(in_ready),
    .ms(t_ms), .s(t_s), .min(t_min), .hr(t_hr), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .err(err), .ovf(ovf)
  );
  watch2count #(.BITS(20)) u1 (
    .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ready(in_ready20),
    .ms(t_ms), .s(t_s), .min(t_min), .hr(t_hr), .out_valid(out_valid20),
    .out_ready(out_ready), .count(count20), .err(err20), .ovf(ovf20)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  task automatic conv(input vec_t v);
    t_hr = v.hr; t_min = v.mi; t_s = v.s; t_ms = v.ms;
    chk("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      chk("out_valid_early", out_valid, 0);
      chk("in_ready_busy", in_ready, 0);
      @(posedge clk); #1;
    end
    chk("out_valid", out_valid, 1);
    chk("out_valid20", out_valid20, 1);
    chk("count", count, v.c);
    chk("err", err, v.e);
    chk("ovf", ovf, v.o);
    chk("count20", count20, v.c20);
    chk("err20", err20, v.e);
    chk("ovf20", ovf20, v.o20);
  endtask
  initial begin
    tbl[0]  = '{4'd0, 7'd0,   7'd0,   11'd0,    26'd0,        1'b0, 1'b0, 20'd0,       1'b0};
    tbl[1]  = '{4'd9, 7'd59,  7'd59,  11'd999,  26'd35999999, 1'b0, 1'b0, 20'd348415,  1'b1};
    tbl[2]  = '{4'd1, 7'd2,   7'd3,   11'd4,    26'd3723004,  1'b0, 1'b0, 20'd577276,  1'b1};
    tbl[3]  = '{4'd0, 7'd0,   7'd0,   11'd1000, 26'd0,        1'b1, 1'b0, 20'd0,       1'b0};
    tbl[4]  = '{4'd0, 7'd0,   7'd60,  11'd0,    26'd0,        1'b1, 1'b0, 20'd0,       1'b0};
    tbl[5]  = '{4'd0, 7'd17,  7'd28,  11'd576,  26'd1048576,  1'b0, 1'b0, 20'd0,       1'b1};
    tbl[6]  = '{4'd0, 7'd17,  7'd28,  11'd575,  26'd1048575,  1'b0, 1'b0, 20'd1048575, 1'b0};
    tbl[7]  = '{4'd10, 7'd0,  7'd0,   11'd0,    26'd0,        1'b1, 1'b0, 20'd0,       1'b0};
    tbl[8]  = '{4'd0, 7'd60,  7'd0,   11'd0,    26'd0,        1'b1, 1'b0, 20'd0,       1'b0};
    tbl[9]  = '{4'd0, 7'd0,   7'd0,   11'd999,  26'd999,      1'b0, 1'b0, 20'd999,     1'b0};
    tbl[10] = '{4'd15, 7'd127, 7'd127, 11'd2047, 26'd0,       1'b1, 1'b0, 20'd0,       1'b0};
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_err", err, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clk); #3 nreset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 11; i++) begin
      conv(tbl[i]);
      @(posedge clk); #1;
      chk("handshake_out_valid", out_valid, 0);
      chk("handshake_in_ready", in_ready, 1);
      chk("hold_count", count, tbl[i].c);
    end
    // backpressure: result held, extra in_valid ignored
    out_ready = 1'b0;
    conv(tbl[2]);
    for (int k = 0; k < 6; k++) begin
      in_valid = (k == 2);
      t_hr = 4'd3; t_min = 7'd3; t_s = 7'd3; t_ms = 11'd3;
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_count", count, 26'd3723004);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    conv(tbl[9]);
    @(posedge clk); #1;
    // reset mid-conversion while in MUL_S
    t_hr = 4'd1; t_min = 7'd0; t_s = 7'd0; t_ms = 11'd0;
    in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 nreset = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_rst_held_in_ready", in_ready, 1);
    chk("mid_rst_held_out_valid", out_valid, 0);
    nreset = 1'b1;
    @(posedge clk); #1;
    conv(tbl[2]);
    @(posedge clk); #1;
    chk("final_idle", in_ready, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
